// File: rtl/screen_ram_arbiter.sv
// screen_ram_arbiter
//
// Shares the single-port 2 KB system RAM between the 6502 CPU bus and the
// video renderer's screen read port. The CPU owns the RAM by default. When
// video asks for it, the grant waits for the next opcode fetch (cpu_sync), or
// for a forced timeout after MAX_WAIT cycles. This keeps an in-flight
// instruction from being torn. While video owns the RAM the CPU is stalled
// and holds its bus. A RELEASE cycle then re-issues the held CPU access so
// that cpu_dout is valid in the first CPU cycle afterwards.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_addr/cpu_we/cpu_din    CPU bus request
//   cpu_sync                   high during a CPU opcode-fetch cycle
//   cpu_dout, cpu_rdy          CPU read data (RAM output) and ready/stall
//   vid_req, vid_addr          video request and read address
//   vid_gnt, vid_data          video grant and read data (1 cycle latency)
//   ram_addr/ram_we/ram_din    RAM request
//   ram_dout                   RAM read data (registered in the RAM)
//   stall_cnt                  only with ARB_STATS_EN: count of cycles with
//                              cpu_rdy low, saturating at 0xFFFF
//
// Optional feature macro: ARB_STATS_EN (adds stall_cnt and its counter).

module screen_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MAX_WAIT   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [7:0]            cpu_din,
    input  logic                  cpu_sync,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_rdy,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_gnt,
    output logic [7:0]            vid_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_din,
    input  logic [7:0]            ram_dout
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        StCpu,
        StWaitSync,
        StVideo,
        StRelease
    } state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_wait_cnt;
    logic              w_take;
    logic              w_cpu_phase;

    // Grant point: next opcode fetch, or forced once the longest instruction
    // has certainly completed. A dropped request never takes.
    assign w_take = (r_state == StWaitSync) && vid_req &&
                    (cpu_sync || (r_wait_cnt == CntW'(MAX_WAIT)));

    assign w_cpu_phase = (r_state == StCpu) || (r_state == StWaitSync);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StCpu;
            r_wait_cnt <= '0;
        end else begin
            unique case (r_state)
                StCpu: begin
                    // A request seen here always spends at least one cycle in
                    // WAIT_SYNC, so a simultaneous cpu_sync is not a take.
                    if (vid_req) begin
                        r_state    <= StWaitSync;
                        r_wait_cnt <= '0;
                    end
                end
                StWaitSync: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (!vid_req) begin
                        r_state <= StCpu;
                    end else if (w_take) begin
                        r_state <= StVideo;
                    end
                end
                StVideo: begin
                    if (!vid_req) begin
                        r_state <= StRelease;
                    end
                end
                StRelease: begin
                    // Always back to CPU for a full cycle before video can
                    // re-arbitrate, even if vid_req is still high.
                    r_state <= StCpu;
                end
                default: begin
                    r_state <= StCpu;
                end
            endcase
        end
    end

    always_comb begin
        cpu_rdy  = 1'b1;
        vid_gnt  = 1'b0;
        ram_addr = cpu_addr;
        unique case (r_state)
            StCpu: begin
                cpu_rdy = 1'b1;
            end
            StWaitSync: begin
                // Freeze the fetch in the take cycle so it is replayed later.
                cpu_rdy = !w_take;
            end
            StVideo: begin
                ram_addr = vid_addr;
                vid_gnt  = 1'b1;
                cpu_rdy  = 1'b0;
            end
            StRelease: begin
                // Re-issue the held CPU access; data is ready next cycle.
                ram_addr = cpu_addr;
                cpu_rdy  = 1'b0;
            end
            default: begin
                cpu_rdy = 1'b1;
            end
        endcase
        ram_we = cpu_we && cpu_rdy && w_cpu_phase;
    end

    assign ram_din  = cpu_din;
    assign cpu_dout = ram_dout;
    assign vid_data = ram_dout;

`ifdef ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!cpu_rdy && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_screen_ram_arbiter.sv
// tb_screen_ram_arbiter
//
// Directed bench for screen_ram_arbiter with a behavioural 2 KB RAM that has
// a 1-cycle registered read. Inputs change 1 time unit after the rising edge;
// outputs are checked 1 time unit later, well before the next edge.

module tb_screen_ram_arbiter;

    localparam int unsigned AW = 11;

    logic          clk;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic          cpu_we;
    logic [7:0]    cpu_din;
    logic          cpu_sync;
    logic [7:0]    cpu_dout;
    logic          cpu_rdy;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic [7:0]    vid_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;
`ifdef ARB_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    int n_checks;
    int n_errors;

    logic [7:0] mem [0:2047];

    screen_ram_arbiter #(
        .ADDR_WIDTH (AW),
        .MAX_WAIT   (7)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_din  (cpu_din),
        .cpu_sync (cpu_sync),
        .cpu_dout (cpu_dout),
        .cpu_rdy  (cpu_rdy),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_gnt  (vid_gnt),
        .vid_data (vid_data),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
`ifdef ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, read-first, 1 cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_we = 1'b1; cpu_din = d;
        cyc();
        cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_addr = '0; cpu_we = 1'b0; cpu_din = '0; cpu_sync = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL reset_rdy: got %b want 1", cpu_rdy); end
        n_checks++; if (vid_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_gnt: got %b want 0", vid_gnt); end
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b want 0", ram_we); end
        cyc();
    endtask

    task automatic test_cpu_rw();
        cpu_addr = 11'h200; cpu_we = 1'b1; cpu_din = 8'h5A;
        #1;
        n_checks++; if (ram_we !== 1'b1) begin n_errors++; $display("FAIL rw_we: got %b want 1", ram_we); end
        n_checks++; if (ram_addr !== 11'h200) begin n_errors++; $display("FAIL rw_addr: got %h want 200", ram_addr); end
        n_checks++; if (ram_din !== 8'h5A) begin n_errors++; $display("FAIL rw_din: got %h want 5a", ram_din); end
        cyc();
        cpu_we = 1'b0;
        #1;
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL rw_we_off: got %b want 0", ram_we); end
        cyc();
        #1;
        n_checks++; if (cpu_dout !== 8'h5A) begin n_errors++; $display("FAIL rw_dout: got %h want 5a", cpu_dout); end
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL rw_rdy: got %b want 1", cpu_rdy); end
        cyc();
    endtask

    task automatic test_sync_grant();
        for (int i = 0; i < 32; i++) cpu_write(11'h200 + 11'(i), 8'(i * 7 + 3));
        cpu_addr = 11'h100;
        // vid_req and cpu_sync together in CPU state: no take yet.
        vid_req = 1'b1; cpu_sync = 1'b1;
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL sg_same_cycle_rdy: got %b want 1", cpu_rdy); end
        n_checks++; if (vid_gnt !== 1'b0) begin n_errors++; $display("FAIL sg_same_cycle_gnt: got %b want 0", vid_gnt); end
        cyc();
        cpu_sync = 1'b0;
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL sg_wait1_rdy: got %b want 1", cpu_rdy); end
        cyc();
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL sg_wait2_rdy: got %b want 1", cpu_rdy); end
        cyc();
        cpu_sync = 1'b1;
        #1;
        n_checks++; if (cpu_rdy !== 1'b0) begin n_errors++; $display("FAIL sg_take_rdy: got %b want 0", cpu_rdy); end
        n_checks++; if (vid_gnt !== 1'b0) begin n_errors++; $display("FAIL sg_take_gnt: got %b want 0", vid_gnt); end
        cyc();
        cpu_sync = 1'b0;
        for (int i = 0; i < 32; i++) begin
            vid_addr = 11'h200 + 11'(i);
            #1;
            if (i == 0) begin
                n_checks++; if (vid_gnt !== 1'b1) begin n_errors++; $display("FAIL sg_gnt: got %b want 1", vid_gnt); end
                n_checks++; if (ram_addr !== 11'h200) begin n_errors++; $display("FAIL sg_ram_addr: got %h want 200", ram_addr); end
                n_checks++; if (cpu_rdy !== 1'b0) begin n_errors++; $display("FAIL sg_vid_rdy: got %b want 0", cpu_rdy); end
            end else begin
                n_checks++;
                if (vid_data !== 8'((i - 1) * 7 + 3)) begin
                    n_errors++;
                    $display("FAIL sg_vid_data[%0d]: got %h want %h", i - 1, vid_data, 8'((i - 1) * 7 + 3));
                end
            end
            cyc();
        end
        vid_req = 1'b0;
        #1;
        n_checks++; if (vid_data !== 8'(31 * 7 + 3)) begin n_errors++; $display("FAIL sg_vid_data[31]: got %h want %h", vid_data, 8'(31 * 7 + 3)); end
        n_checks++; if (vid_gnt !== 1'b1) begin n_errors++; $display("FAIL sg_last_gnt: got %b want 1", vid_gnt); end
        cyc();
        #1;
        n_checks++; if (cpu_rdy !== 1'b0) begin n_errors++; $display("FAIL sg_rel_rdy: got %b want 0", cpu_rdy); end
        n_checks++; if (vid_gnt !== 1'b0) begin n_errors++; $display("FAIL sg_rel_gnt: got %b want 0", vid_gnt); end
        n_checks++; if (ram_addr !== 11'h100) begin n_errors++; $display("FAIL sg_rel_addr: got %h want 100", ram_addr); end
        cyc();
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL sg_back_rdy: got %b want 1", cpu_rdy); end
        cyc();
    endtask

    task automatic test_timeout();
        vid_req = 1'b1; cpu_sync = 1'b0;
        cyc();
        for (int k = 0; k < 7; k++) begin
            #1;
            n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL to_wait_rdy[%0d]: got %b want 1", k, cpu_rdy); end
            cyc();
        end
        #1;
        n_checks++; if (cpu_rdy !== 1'b0) begin n_errors++; $display("FAIL to_force_rdy: got %b want 0", cpu_rdy); end
        n_checks++; if (vid_gnt !== 1'b0) begin n_errors++; $display("FAIL to_force_gnt: got %b want 0", vid_gnt); end
        cyc();
        #1;
        n_checks++; if (vid_gnt !== 1'b1) begin n_errors++; $display("FAIL to_video_gnt: got %b want 1", vid_gnt); end
        vid_req = 1'b0;
        cyc();
        cyc();
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL to_back_rdy: got %b want 1", cpu_rdy); end
        cyc();
    endtask

    task automatic test_drop_in_wait();
        vid_req = 1'b1;
        cyc();
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL dw_wait_rdy: got %b want 1", cpu_rdy); end
        cyc();
        vid_req = 1'b0;
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL dw_drop_rdy: got %b want 1", cpu_rdy); end
        cyc();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL dw_after_rdy[%0d]: got %b want 1", k, cpu_rdy); end
            n_checks++; if (vid_gnt !== 1'b0) begin n_errors++; $display("FAIL dw_after_gnt[%0d]: got %b want 0", k, vid_gnt); end
            cyc();
        end
    endtask

    task automatic test_held_read();
        cpu_write(11'h010, 8'h33);
        cpu_addr = 11'h010; vid_req = 1'b1; vid_addr = 11'h300;
        cyc();
        cpu_sync = 1'b1;
        #1;
        n_checks++; if (cpu_rdy !== 1'b0) begin n_errors++; $display("FAIL hr_take_rdy: got %b want 0", cpu_rdy); end
        cyc();
        cpu_sync = 1'b0; cpu_we = 1'b1; cpu_din = 8'hEE;
        #1;
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL hr_video_we: got %b want 0", ram_we); end
        n_checks++; if (ram_addr !== 11'h300) begin n_errors++; $display("FAIL hr_video_addr: got %h want 300", ram_addr); end
        cyc();
        vid_req = 1'b0;
        #1;
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL hr_video_we2: got %b want 0", ram_we); end
        cyc();
        vid_req = 1'b1;
        #1;
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL hr_rel_we: got %b want 0", ram_we); end
        n_checks++; if (ram_addr !== 11'h010) begin n_errors++; $display("FAIL hr_rel_addr: got %h want 010", ram_addr); end
        n_checks++; if (cpu_rdy !== 1'b0) begin n_errors++; $display("FAIL hr_rel_rdy: got %b want 0", cpu_rdy); end
        cyc();
        cpu_we = 1'b0;
        #1;
        n_checks++; if (cpu_dout !== 8'h33) begin n_errors++; $display("FAIL hr_dout: got %h want 33", cpu_dout); end
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL hr_cpu_rdy: got %b want 1", cpu_rdy); end
        n_checks++; if (mem[11'h010] !== 8'h33) begin n_errors++; $display("FAIL hr_mem: got %h want 33", mem[11'h010]); end
        cyc();
        vid_req = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_glitch();
        vid_req = 1'b1;
        cyc();
        cpu_sync = 1'b1;
        cyc();
        cpu_sync = 1'b0; vid_req = 1'b0;
        #1;
        n_checks++; if (vid_gnt !== 1'b1) begin n_errors++; $display("FAIL gl_video_gnt: got %b want 1", vid_gnt); end
        cyc();
        vid_req = 1'b1;
        #1;
        n_checks++; if (vid_gnt !== 1'b0) begin n_errors++; $display("FAIL gl_rel_gnt: got %b want 0", vid_gnt); end
        n_checks++; if (cpu_rdy !== 1'b0) begin n_errors++; $display("FAIL gl_rel_rdy: got %b want 0", cpu_rdy); end
        cyc();
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL gl_cpu_rdy: got %b want 1", cpu_rdy); end
        n_checks++; if (vid_gnt !== 1'b0) begin n_errors++; $display("FAIL gl_cpu_gnt: got %b want 0", vid_gnt); end
        cyc();
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL gl_rewait_rdy: got %b want 1", cpu_rdy); end
        vid_req = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset_in_video();
        vid_req = 1'b1;
        cyc();
        cpu_sync = 1'b1;
        cyc();
        cpu_sync = 1'b0; reset = 1'b1;
        #1;
        n_checks++; if (vid_gnt !== 1'b1) begin n_errors++; $display("FAIL rv_pre_gnt: got %b want 1", vid_gnt); end
        cyc();
        reset = 1'b0; vid_req = 1'b0;
        #1;
        n_checks++; if (vid_gnt !== 1'b0) begin n_errors++; $display("FAIL rv_gnt: got %b want 0", vid_gnt); end
        n_checks++; if (cpu_rdy !== 1'b1) begin n_errors++; $display("FAIL rv_rdy: got %b want 1", cpu_rdy); end
`ifdef ARB_STATS_EN
        n_checks++; if (stall_cnt !== 16'd0) begin n_errors++; $display("FAIL rv_stall_cnt: got %0d want 0", stall_cnt); end
`endif
        cyc();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_cpu_rw();
        test_sync_grant();
        test_timeout();
        test_drop_in_wait();
        test_held_read();
        test_glitch();
        test_reset_in_video();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
